// File: rtl/seg_scan_ctrl.sv
// Dynamic 7-segment scan controller: prescaled digit rotation over an enable mask,
// registered digit-select/segment outputs and a frame-complete pulse.
module seg_scan_ctrl #(
    parameter int DIG_NUM     = 8,
    parameter int DIV_MAX     = 50_000,
    parameter bit SEL_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1,
    localparam int IDX_W      = $clog2(DIG_NUM),
    localparam int CNT_W      = $clog2(DIV_MAX)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   scan_en,
    input  logic                   dir,
    input  logic [DIG_NUM-1:0]     dig_mask,
    input  logic [8*DIG_NUM-1:0]   seg_data,
    output logic [DIG_NUM-1:0]     sel,
    output logic [7:0]             seg,
    output logic [IDX_W-1:0]       scan_idx,
    output logic                   frame_done
);

    localparam logic [DIG_NUM-1:0] SEL_OFF   = {DIG_NUM{SEL_ACT_LOW}};
    localparam logic [7:0]         SEG_BLANK = {8{SEG_ACT_LOW}};
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DIV_MAX - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [DIG_NUM-1:0] sel_q, sel_d;
    logic [7:0]         seg_q, seg_d;
    logic               frame_done_q, frame_done_d;

    logic               tick;
    logic [IDX_W-1:0]   nxt_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               nxt_found;
    logic               wrap;
    logic [DIG_NUM-1:0] hit;
    logic [7:0]         seg_pick;
    int                 cur;
    int                 cand;

    // Prescaler
    always_comb begin
        tick  = scan_en && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (scan_en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Cyclic search for the next enabled digit. Walking the offsets from the
    // far end down to 1 leaves the nearest hit as the final assignment; the
    // last offset (DIG_NUM) lands on the current index itself.
    always_comb begin
        nxt_idx   = scan_idx_q;
        nxt_found = 1'b0;
        cur       = int'(scan_idx_q);
        cand      = 0;
        cand_idx  = '0;
        for (int k = DIG_NUM; k >= 1; k--) begin
            cand     = dir ? (cur + DIG_NUM - k) % DIG_NUM : (cur + k) % DIG_NUM;
            cand_idx = IDX_W'(cand);
            if (dig_mask[cand_idx]) begin
                nxt_idx   = cand_idx;
                nxt_found = 1'b1;
            end
        end
        wrap = dir ? (nxt_idx >= scan_idx_q) : (nxt_idx <= scan_idx_q);
    end

    always_comb begin
        scan_idx_d   = scan_idx_q;
        frame_done_d = 1'b0;
        if (tick && nxt_found) begin
            scan_idx_d   = nxt_idx;
            frame_done_d = wrap;
        end
    end

    // hit is one-hot or zero by construction, which rules out ghosting on sel
    always_comb begin
        hit      = '0;
        seg_pick = SEG_BLANK;
        for (int i = 0; i < DIG_NUM; i++) begin
            hit[i] = (scan_idx_q == IDX_W'(i)) && dig_mask[i];
            if (hit[i]) begin
                seg_pick = seg_data[8*i +: 8];
            end
        end
        sel_d = SEL_ACT_LOW ? ~hit : hit;
        seg_d = (|hit) ? seg_pick : SEG_BLANK;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q        <= '0;
            scan_idx_q   <= '0;
            sel_q        <= SEL_OFF;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            scan_idx_q   <= scan_idx_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign scan_idx   = scan_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (active-low and active-high polarity) sharing
// stimulus, a per-cycle scoreboard model, a slot-level vector table and corner sequences.
module tb_seg_scan_ctrl;

    localparam int DIG = 4;
    localparam int DIV = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        scan_en = 1'b1;
    logic        dir     = 1'b0;
    logic [3:0]  dig_mask = 4'hF;
    logic [31:0] seg_data = 32'h4F5B063F;

    logic [3:0] sel_lo, sel_hi;
    logic [7:0] seg_lo, seg_hi;
    logic [1:0] idx_lo, idx_hi;
    logic       fd_lo, fd_hi;

    int n_chk = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    seg_scan_ctrl #(.DIG_NUM(DIG), .DIV_MAX(DIV), .SEL_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut_lo (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .scan_en(scan_en), .dir(dir),
        .dig_mask(dig_mask), .seg_data(seg_data),
        .sel(sel_lo), .seg(seg_lo), .scan_idx(idx_lo), .frame_done(fd_lo)
    );

    seg_scan_ctrl #(.DIG_NUM(DIG), .DIV_MAX(DIV), .SEL_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)) dut_hi (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .scan_en(scan_en), .dir(dir),
        .dig_mask(dig_mask), .seg_data(seg_data),
        .sel(sel_hi), .seg(seg_hi), .scan_idx(idx_hi), .frame_done(fd_hi)
    );

    typedef struct {
        logic [3:0] sel_lo;
        logic [3:0] sel_hi;
        logic [7:0] seg_lo;
        logic [7:0] seg_hi;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic       dir;
        logic [3:0] mask;
        logic [3:0] pre_sel;
        logic [1:0] idx;
        logic       fd;
    } vec_t;

    vec_t vecs[17];

    int         m_cnt = 0;
    int         m_idx = 0;
    logic       m_fd  = 1'b0;
    logic [3:0] m_hot = 4'h0;
    logic [7:0] m_data = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs held across it
    task automatic model_edge();
        int   old_i;
        int   j;
        logic found;
        logic tk;
        if (sys_rst) begin
            m_cnt = 0; m_idx = 0; m_hot = 4'h0; m_data = 8'h00; m_fd = 1'b0;
            return;
        end
        m_hot  = dig_mask[m_idx] ? (4'b0001 << m_idx) : 4'b0000;
        m_data = seg_data[8*m_idx +: 8];
        tk     = scan_en && (m_cnt == DIV - 1);
        m_fd   = 1'b0;
        if (scan_en) m_cnt = tk ? 0 : m_cnt + 1;
        if (tk) begin
            old_i = m_idx;
            j     = m_idx;
            found = 1'b0;
            for (int s = 0; s < DIG && !found; s++) begin
                j = dir ? (j + DIG - 1) % DIG : (j + 1) % DIG;
                if (dig_mask[j]) found = 1'b1;
            end
            if (found) begin
                m_fd  = dir ? (j >= old_i) : (j <= old_i);
                m_idx = j;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge sys_clk);
        model_edge();
        e.sel_lo = (m_hot != 0) ? ~m_hot : 4'hF;
        e.sel_hi = m_hot;
        e.seg_lo = (m_hot != 0) ? m_data : 8'hFF;
        e.seg_hi = (m_hot != 0) ? m_data : 8'h00;
        e.idx    = 2'(m_idx);
        e.fd     = m_fd;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk("sb_sel_lo", 32'(sel_lo), 32'(e.sel_lo));
        chk("sb_sel_hi", 32'(sel_hi), 32'(e.sel_hi));
        chk("sb_seg_lo", 32'(seg_lo), 32'(e.seg_lo));
        chk("sb_seg_hi", 32'(seg_hi), 32'(e.seg_hi));
        chk("sb_idx_lo", 32'(idx_lo), 32'(e.idx));
        chk("sb_idx_hi", 32'(idx_hi), 32'(e.idx));
        chk("sb_fd_lo", 32'(fd_lo), 32'(e.fd));
        chk("sb_fd_hi", 32'(fd_hi), 32'(e.fd));
        chk("ghost_lo", 32'($countones(~sel_lo) <= 1), 32'd1);
        chk("ghost_hi", 32'($countones(sel_hi) <= 1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // dir, mask, sel just before the tick, idx and frame_done just after it
        vecs[0]  = '{1'b0, 4'hF, 4'b1110, 2'd1, 1'b0};
        vecs[1]  = '{1'b0, 4'hF, 4'b1101, 2'd2, 1'b0};
        vecs[2]  = '{1'b0, 4'hF, 4'b1011, 2'd3, 1'b0};
        vecs[3]  = '{1'b0, 4'hF, 4'b0111, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 4'hF, 4'b1110, 2'd3, 1'b1};
        vecs[5]  = '{1'b1, 4'hF, 4'b0111, 2'd2, 1'b0};
        vecs[6]  = '{1'b1, 4'hF, 4'b1011, 2'd1, 1'b0};
        vecs[7]  = '{1'b1, 4'hF, 4'b1101, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 4'h5, 4'b1110, 2'd2, 1'b0};
        vecs[9]  = '{1'b0, 4'h5, 4'b1011, 2'd0, 1'b1};
        vecs[10] = '{1'b0, 4'h5, 4'b1110, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 4'h4, 4'b1011, 2'd2, 1'b1};
        vecs[12] = '{1'b0, 4'h4, 4'b1011, 2'd2, 1'b1};
        vecs[13] = '{1'b0, 4'h0, 4'b1111, 2'd2, 1'b0};
        vecs[14] = '{1'b0, 4'h0, 4'b1111, 2'd2, 1'b0};
        vecs[15] = '{1'b0, 4'h9, 4'b1111, 2'd3, 1'b0};
        vecs[16] = '{1'b0, 4'h9, 4'b0111, 2'd0, 1'b1};

        step();
        step();
        chk("rst_sel_lo", 32'(sel_lo), 32'hF);
        chk("rst_sel_hi", 32'(sel_hi), 32'h0);
        chk("rst_seg_lo", 32'(seg_lo), 32'hFF);
        chk("rst_seg_hi", 32'(seg_hi), 32'h00);
        chk("rst_idx", 32'(idx_lo), 32'd0);
        chk("rst_fd", 32'(fd_lo), 32'd0);

        sys_rst = 1'b0;
        foreach (vecs[v]) begin
            dig_mask = vecs[v].mask;
            dir      = vecs[v].dir;
            step(); step(); step();
            chk($sformatf("vec%0d_pre_sel", v), 32'(sel_lo), 32'(vecs[v].pre_sel));
            step();
            chk($sformatf("vec%0d_idx", v), 32'(idx_lo), 32'(vecs[v].idx));
            chk($sformatf("vec%0d_fd", v), 32'(fd_lo), 32'(vecs[v].fd));
        end

        // Freeze mid-slot: index held, seg keeps tracking data, slot resumes where it stopped
        dig_mask = 4'hF;
        step(); step();
        scan_en = 1'b0;
        repeat (10) step();
        chk("freeze_idx", 32'(idx_lo), 32'd0);
        seg_data[7:0] = 8'h77;
        step();
        chk("freeze_seg", 32'(seg_lo), 32'h77);
        scan_en = 1'b1;
        n = 0;
        while (idx_lo == 2'd0 && n < 20) begin
            step();
            n++;
        end
        chk("freeze_remaining", 32'(n), 32'd2);
        chk("freeze_next_idx", 32'(idx_lo), 32'd1);

        // Clear the shown digit's mask bit mid-slot
        step();
        dig_mask = 4'h9;
        step();
        chk("maskclr_sel_lo", 32'(sel_lo), 32'hF);
        chk("maskclr_seg_hi", 32'(seg_hi), 32'h00);
        step(); step();
        chk("maskclr_next_idx", 32'(idx_lo), 32'd3);

        // Reset mid-slot, then first tick exactly DIV cycles after release
        step();
        sys_rst = 1'b1;
        step();
        chk("mrst_sel_lo", 32'(sel_lo), 32'hF);
        chk("mrst_sel_hi", 32'(sel_hi), 32'h0);
        chk("mrst_seg_lo", 32'(seg_lo), 32'hFF);
        chk("mrst_seg_hi", 32'(seg_hi), 32'h00);
        chk("mrst_idx_hi", 32'(idx_hi), 32'd0);
        chk("mrst_fd", 32'(fd_lo), 32'd0);
        sys_rst = 1'b0;
        n = 0;
        while (idx_lo == 2'd0 && n < 20) begin
            step();
            n++;
        end
        chk("first_tick_latency", 32'(n), 32'(DIV));
        chk("first_tick_idx", 32'(idx_lo), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised dynamic 7-segment scan controller for the course-experiment display boards. It generalises the fixed 8-digit, 1 s rotating digit select into a block with:
- configurable digit count, scan rate and polarity
- selectable scan direction and per-digit enable mask
- built-in segment-data multiplexing and a frame-complete pulse

It sits between the digit-data/decoder logic and the board's digit-select and segment pins.

Parameters:
DIG_NUM, 8, number of digits scanned (2..16).
DIV_MAX, 50_000, sys_clk cycles per digit slot (1 ms at 50 MHz); must be ≥2.
SEL_ACT_LOW, 1, 1 = digit select active-low, 0 = active-high.
SEG_ACT_LOW, 1, 1 = segment lines active-low (blank = all 1), 0 = active-high (blank = all 0).

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst  in  1  synchronous reset, active-high.
scan_en  in  1  1 = prescaler runs and scanning advances; 0 = freeze.
dir  in  1  0 = ascending index (0→DIG_NUM-1), 1 = descending.
dig_mask  in  DIG_NUM  per-digit enable; bit i = 1 means digit i is displayed and visited.
seg_data  in  8*DIG_NUM  segment pattern per digit; digit i = bits [8i+7:8i], already in SEG_ACT_LOW polarity.
sel  out  DIG_NUM  digit select, one-hot in active polarity.
seg  out  8  segment output for the selected digit.
scan_idx  out  clog2(DIG_NUM)  index currently held.
frame_done  out  1  one-cycle pulse when the scan wraps.

Behaviour:
- Clock and reset: single clock sys_clk; synchronous active-high reset sys_rst; all state updates on the posedge.
- Reset values:
  - prescaler cnt = 0, scan_idx = 0
  - sel = all inactive (all 1 if SEL_ACT_LOW, else all 0)
  - seg = blank, frame_done = 0
  - Reset has priority over every other input and aborts any slot mid-count.
- Prescaler:
  - When scan_en = 1, cnt counts 0..DIV_MAX-1 and wraps to 0.
  - tick = scan_en and (cnt == DIV_MAX-1).
  - When scan_en = 0, cnt holds.
- Index advance on tick:
  - scan_idx moves to the next index in direction dir whose dig_mask bit is 1, searching cyclically. The search starts at idx±1 and may land back on idx itself.
  - If dig_mask = 0, scan_idx holds.
  - Without a tick, scan_idx holds.
  - dir and dig_mask are sampled on the tick cycle only; a change between ticks takes effect at the next tick.
- frame_done:
  - Asserted for exactly one cycle, the cycle after the tick, when the new index wraps:
    - dir = 0: new idx ≤ old idx.
    - dir = 1: new idx ≥ old idx.
  - A single enabled digit therefore pulses on every tick.
  - Never asserted when dig_mask = 0.
- Outputs:
  - sel and seg are registered from the current scan_idx, dig_mask and seg_data, so latency is 1 cycle from any change of those.
  - If dig_mask[scan_idx] = 1: sel has only bit scan_idx active, and seg = seg_data digit scan_idx.
  - Otherwise sel is all inactive and seg is blank. This covers a mask cleared mid-slot and the post-reset case where digit 0 is disabled.
  - seg_data changes within a slot appear on seg the next cycle.
- Freeze (scan_en = 0): outputs keep tracking seg_data and dig_mask for the held index; there is no flicker and no tick.
- Ghosting: sel never has more than one bit active in any cycle.

Test Plan:
1. DIG_NUM=4, DIV_MAX=4, SEL_ACT_LOW=1, mask=4'b1111, dir=0, scan_en=1, reset released → sel cycles 1110, 1101, 1011, 0111, changing every 4 clocks; frame_done pulses once per 16 clocks, the cycle after idx 3→0.
2. Same setup with dir=1 → scan_idx sequence 0, 3, 2, 1, 0; frame_done pulses after 0→3.
3. mask=4'b0101 → scan_idx alternates 0, 2; sel alternates 1110 / 1011; frame_done on each 2→0. Then mask=4'b0100 → idx stays 2 and frame_done pulses every tick.
4. mask=0 → sel=1111, seg=8'hFF, frame_done never asserts. Then clear mask[idx] mid-slot → sel blanks within 1 cycle; on the next tick idx advances to the next enabled digit.
5. Drop scan_en mid-slot for 10 cycles → cnt and scan_idx are held. Change seg_data for the held digit → seg updates after 1 cycle. Raise scan_en → the slot completes the remaining counts.
6. Assert sys_rst mid-slot, checked across both SEL_ACT_LOW settings → on the next clock all outputs take their reset values. After release, the first tick occurs exactly DIV_MAX cycles later.
